// File: rtl/dac_update_scheduler.sv
// Two-requester sample scheduler feeding a dual-channel DAC at a programmable update rate.
// Optional build macro DAC_SLEW_LIMIT_EN limits the per-update code change to SLEW_STEP.
module dac_update_scheduler #(
  parameter int          DIV_W     = 16,
  parameter logic [13:0] MUTE_CODE = 14'h2000,
  parameter logic [13:0] SLEW_STEP = 14'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             r0_valid,
  input  logic             r0_chan,
  input  logic [13:0]      r0_data,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic             r1_chan,
  input  logic [13:0]      r1_data,
  output logic             r1_ready,
  input  logic             clr_ovr,
  output logic [13:0]      dac_a,
  output logic [13:0]      dac_b,
  output logic             dac_update,
  output logic [1:0]       ovr,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [13:0]      r_shadow_a, r_shadow_b;
  logic [13:0]      r_dac_a, r_dac_b;
  logic [1:0]       r_dirty, r_written, r_ovr;
  logic             r_rr_ptr;
  logic             r_dac_update;

  logic             w_gnt_ok, w_r0_ready, w_r1_ready, w_xfer, w_xfer_ch, w_tick, w_flush_entry;
  logic [13:0]      w_xfer_data, w_shadow_a_nxt, w_shadow_b_nxt, w_dac_a_nxt, w_dac_b_nxt;
  logic [1:0]       w_xfer_mask, w_ovr_set;

  // Move cur toward tgt by at most SLEW_STEP without overshoot or wrap.
  function automatic logic [13:0] f_slew(input logic [13:0] cur, input logic [13:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    else
      return ((cur - tgt) > SLEW_STEP) ? cur - SLEW_STEP : tgt;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = ARM;
      ARM:     if (!enable) w_state_nxt = FLUSH;
               else if (&r_written) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Round-robin: on contention the requester not granted last wins.
  assign w_gnt_ok    = (r_state == ARM) || (r_state == RUN);
  assign w_r0_ready  = w_gnt_ok & r0_valid & (~r1_valid | r_rr_ptr);
  assign w_r1_ready  = w_gnt_ok & r1_valid & (~r0_valid | ~r_rr_ptr);
  assign w_xfer      = w_r0_ready | w_r1_ready;
  assign w_xfer_ch   = w_r0_ready ? r0_chan : r1_chan;
  assign w_xfer_data = w_r0_ready ? r0_data : r1_data;
  assign w_xfer_mask = {w_xfer & w_xfer_ch, w_xfer & ~w_xfer_ch};

  // Tick is gated by enable so a disabling cycle always resolves to the mute path.
  assign w_tick        = (r_state == RUN) && enable && (r_cnt >= rate_div);
  assign w_flush_entry = (w_state_nxt == FLUSH) && (r_state != FLUSH);
  assign w_ovr_set     = w_tick ? 2'b00 : (w_xfer_mask & r_dirty);

  assign w_shadow_a_nxt = w_xfer_mask[0] ? w_xfer_data : r_shadow_a;
  assign w_shadow_b_nxt = w_xfer_mask[1] ? w_xfer_data : r_shadow_b;

`ifdef DAC_SLEW_LIMIT_EN
  assign w_dac_a_nxt = f_slew(r_dac_a, w_shadow_a_nxt);
  assign w_dac_b_nxt = f_slew(r_dac_b, w_shadow_b_nxt);
`else
  assign w_dac_a_nxt = w_shadow_a_nxt;
  assign w_dac_b_nxt = w_shadow_b_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dac_a      <= MUTE_CODE;
      r_dac_b      <= MUTE_CODE;
      r_dac_update <= 1'b0;
      r_ovr        <= 2'b00;
      r_shadow_a   <= MUTE_CODE;
      r_shadow_b   <= MUTE_CODE;
      r_dirty      <= 2'b00;
      r_written    <= 2'b00;
      r_rr_ptr     <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (r_state == RUN && w_state_nxt == RUN && !w_tick) ? r_cnt + 1'b1 : '0;
      r_ovr        <= (clr_ovr ? 2'b00 : r_ovr) | w_ovr_set;
      r_dac_update <= 1'b0;
      if (w_xfer) r_rr_ptr <= w_r1_ready;

      if (r_state == FLUSH) begin
        r_shadow_a <= MUTE_CODE;
        r_shadow_b <= MUTE_CODE;
        r_dirty    <= 2'b00;
        r_written  <= 2'b00;
      end else begin
        r_shadow_a <= w_shadow_a_nxt;
        r_shadow_b <= w_shadow_b_nxt;
        r_dirty    <= w_tick ? 2'b00 : (r_dirty | w_xfer_mask);
        r_written  <= r_written | w_xfer_mask;
      end

      if (w_flush_entry) begin
        r_dac_a      <= MUTE_CODE;
        r_dac_b      <= MUTE_CODE;
        r_dac_update <= 1'b1;
      end else if (w_tick) begin
        r_dac_a      <= w_dac_a_nxt;
        r_dac_b      <= w_dac_b_nxt;
        r_dac_update <= 1'b1;
      end
    end
  end

  assign r0_ready   = w_r0_ready;
  assign r1_ready   = w_r1_ready;
  assign dac_a      = r_dac_a;
  assign dac_b      = r_dac_b;
  assign dac_update = r_dac_update;
  assign ovr        = r_ovr;
  assign state      = r_state;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed self-checking bench for dac_update_scheduler.
module tb_dac_update_scheduler;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst, enable, clr_ovr;
  logic [DIV_W-1:0] rate_div;
  logic             r0_valid, r0_chan, r0_ready;
  logic             r1_valid, r1_chan, r1_ready;
  logic [13:0]      r0_data, r1_data, dac_a, dac_b;
  logic             dac_update;
  logic [1:0]       ovr, state;
  int               n_checks = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  dac_update_scheduler #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rate_div(rate_div),
    .r0_valid(r0_valid), .r0_chan(r0_chan), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_chan(r1_chan), .r1_data(r1_data), .r1_ready(r1_ready),
    .clr_ovr(clr_ovr), .dac_a(dac_a), .dac_b(dac_b), .dac_update(dac_update),
    .ovr(ovr), .state(state)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; clr_ovr = 1'b0; rate_div = '0;
    r0_valid = 1'b0; r0_chan = 1'b0; r0_data = '0;
    r1_valid = 1'b0; r1_chan = 1'b0; r1_data = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  // Reset, write A then B from r0 while armed; returns in the first RUN cycle (cnt=0).
  task automatic arm_run(input logic [DIV_W-1:0] rdiv, input logic [13:0] a, input logic [13:0] b);
    do_reset;
    rate_div = rdiv;
    enable = 1'b1;
    step;
    r0_valid = 1'b1; r0_chan = 1'b0; r0_data = a;
    step;
    r0_chan = 1'b1; r0_data = b;
    step;
    r0_valid = 1'b0;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    n_checks++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d want=0", state); end
    n_checks++; if (dac_a !== 14'h2000) begin n_err++; $display("FAIL rst_dac_a got=%h want=2000", dac_a); end
    n_checks++; if (dac_b !== 14'h2000) begin n_err++; $display("FAIL rst_dac_b got=%h want=2000", dac_b); end
    n_checks++; if (dac_update !== 1'b0) begin n_err++; $display("FAIL rst_update got=%b want=0", dac_update); end
    n_checks++; if (ovr !== 2'b00) begin n_err++; $display("FAIL rst_ovr got=%b want=00", ovr); end
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) begin n_err++; $display("FAIL idle_ready got=%b want=00", {r0_ready, r1_ready}); end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_arm;
    arm_run(3, 14'd100, 14'd200);
    n_checks++; if (state !== 2'd2) begin n_err++; $display("FAIL arm_state got=%0d want=2", state); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        step;
        n_checks++; if (dac_update !== 1'b0) begin n_err++; $display("FAIL arm_quiet p=%0d i=%0d got=%b want=0", p, i, dac_update); end
      end
      step;
      n_checks++; if (dac_update !== 1'b1) begin n_err++; $display("FAIL arm_update p=%0d got=%b want=1", p, dac_update); end
      n_checks++; if (dac_a !== 14'd100) begin n_err++; $display("FAIL arm_dac_a got=%0d want=100", dac_a); end
      n_checks++; if (dac_b !== 14'd200) begin n_err++; $display("FAIL arm_dac_b got=%0d want=200", dac_b); end
    end
  endtask

  task automatic test_overrun;
    int k;
    arm_run(9, 14'd1, 14'd2);
    repeat (10) step;
    n_checks++; if (dac_update !== 1'b1 || dac_a !== 14'd1) begin n_err++; $display("FAIL ovr_first_upd got=%b/%0d want=1/1", dac_update, dac_a); end
    r0_valid = 1'b1; r0_chan = 1'b0; r0_data = 14'd5;
    step;
    n_checks++; if (ovr !== 2'b00) begin n_err++; $display("FAIL ovr_first_write got=%b want=00", ovr); end
    r0_data = 14'd6;
    step;
    r0_valid = 1'b0;
    n_checks++; if (ovr !== 2'b01) begin n_err++; $display("FAIL ovr_set got=%b want=01", ovr); end
    for (k = 0; k < 20; k++) begin
      step;
      if (dac_update) break;
    end
    n_checks++; if (k !== 7) begin n_err++; $display("FAIL ovr_upd_wait got=%0d want=7", k); end
    n_checks++; if (dac_a !== 14'd6) begin n_err++; $display("FAIL ovr_dac_a got=%0d want=6", dac_a); end
    n_checks++; if (ovr !== 2'b01) begin n_err++; $display("FAIL ovr_sticky got=%b want=01", ovr); end
    clr_ovr = 1'b1; r0_valid = 1'b1; r0_data = 14'd7;
    step;
    n_checks++; if (ovr !== 2'b00) begin n_err++; $display("FAIL ovr_clear got=%b want=00", ovr); end
    r0_data = 14'd8;
    step;
    r0_valid = 1'b0;
    n_checks++; if (ovr !== 2'b01) begin n_err++; $display("FAIL ovr_set_wins got=%b want=01", ovr); end
    step;
    clr_ovr = 1'b0;
    #1;
    n_checks++; if (ovr !== 2'b00) begin n_err++; $display("FAIL ovr_clear2 got=%b want=00", ovr); end
  endtask

  task automatic test_contention;
    do_reset;
    enable = 1'b1;
    step;
    r0_valid = 1'b1; r0_chan = 1'b0; r0_data = 14'd10;
    r1_valid = 1'b1; r1_chan = 1'b1; r1_data = 14'd20;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL contention i=%0d got=%b want=%b", i, {r0_ready, r1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step;
    end
    r0_valid = 1'b0;
    #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b01) begin n_err++; $display("FAIL single_r1 got=%b want=01", {r0_ready, r1_ready}); end
    r1_valid = 1'b0;
  endtask

  task automatic test_disable;
    arm_run(3, 14'd100, 14'd200);
    repeat (4) step;
    n_checks++; if (dac_update !== 1'b1 || dac_a !== 14'd100) begin n_err++; $display("FAIL dis_pre got=%b/%0d want=1/100", dac_update, dac_a); end
    enable = 1'b0;
    step;
    n_checks++; if (state !== 2'd3) begin n_err++; $display("FAIL dis_flush got=%0d want=3", state); end
    n_checks++; if (dac_update !== 1'b1) begin n_err++; $display("FAIL dis_pulse got=%b want=1", dac_update); end
    n_checks++; if (dac_a !== 14'h2000 || dac_b !== 14'h2000) begin n_err++; $display("FAIL dis_mute got=%h/%h want=2000/2000", dac_a, dac_b); end
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) begin n_err++; $display("FAIL flush_ready got=%b want=00", {r0_ready, r1_ready}); end
    step;
    n_checks++; if (state !== 2'd0) begin n_err++; $display("FAIL dis_idle got=%0d want=0", state); end
    n_checks++; if (dac_update !== 1'b0 || dac_a !== 14'h2000) begin n_err++; $display("FAIL dis_hold got=%b/%h want=0/2000", dac_update, dac_a); end
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) begin n_err++; $display("FAIL idle_ready2 got=%b want=00", {r0_ready, r1_ready}); end
    r1_valid = 1'b0; r0_chan = 1'b0; r0_data = 14'd50;
    enable = 1'b1;
    step;
    step;
    r0_valid = 1'b0;
    step;
    step;
    n_checks++; if (state !== 2'd1) begin n_err++; $display("FAIL rearm_written got=%0d want=1", state); end
  endtask

  task automatic test_boundary;
    arm_run(0, 14'd1, 14'd2);
    r0_valid = 1'b1; r0_chan = 1'b1; r0_data = 14'd7;
    step;
    r0_valid = 1'b0;
    n_checks++; if (dac_update !== 1'b1 || dac_b !== 14'd7) begin n_err++; $display("FAIL div0_b got=%b/%0d want=1/7", dac_update, dac_b); end
    n_checks++; if (dac_a !== 14'd1) begin n_err++; $display("FAIL div0_a got=%0d want=1", dac_a); end
    n_checks++; if (ovr !== 2'b00) begin n_err++; $display("FAIL div0_ovr got=%b want=00", ovr); end
    step;
    n_checks++; if (dac_update !== 1'b1) begin n_err++; $display("FAIL div0_every got=%b want=1", dac_update); end
    arm_run(20, 14'd1, 14'd2);
    repeat (10) step;
    n_checks++; if (dac_update !== 1'b0) begin n_err++; $display("FAIL rdiv_pre got=%b want=0", dac_update); end
    rate_div = 2;
    step;
    n_checks++; if (dac_update !== 1'b1) begin n_err++; $display("FAIL rdiv_drop got=%b want=1", dac_update); end
  endtask

  task automatic test_reset_run;
    arm_run(3, 14'd100, 14'd200);
    repeat (3) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_checks++; if (dac_update !== 1'b0) begin n_err++; $display("FAIL rstrun_pulse got=%b want=0", dac_update); end
    n_checks++; if (state !== 2'd0 || dac_a !== 14'h2000) begin n_err++; $display("FAIL rstrun_state got=%0d/%h want=0/2000", state, dac_a); end
    step;
    n_checks++; if (dac_update !== 1'b0) begin n_err++; $display("FAIL rstrun_after got=%b want=0", dac_update); end
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  task automatic test_slew;
    int exp_a;
    arm_run(0, 14'd300, 14'h2000);
    exp_a = 14'h2000;
    for (int i = 0; i < 130; i++) begin
      step;
      exp_a = (exp_a - 64 > 300) ? exp_a - 64 : 300;
      n_checks++; if (dac_a !== exp_a[13:0]) begin n_err++; $display("FAIL slew i=%0d got=%0d want=%0d", i, dac_a, exp_a); end
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_contention;
    test_disable;
    test_reset_run;
`ifdef DAC_SLEW_LIMIT_EN
    test_slew;
`else
    test_arm;
    test_overrun;
    test_boundary;
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
